ras_ctrl: RTL

RAS_CTRL -- requirements
Module: ras_ctrl

---
 rtl/ras_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ras_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ras_ctrl
// Brief   : Speculative return-address-stack controller with commit/flush
//           recovery. Optional macro: RAS_UNDERFLOW_GUARD_EN.
// Revision: 1.0
// ============================================================================
module ras_ctrl #(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_call,
    input  logic                              req_ret,
    input  logic [WIDTH-1:0]                  req_data,
    input  logic                              commit_i,
    input  logic                              flush,
    output logic                              trigger,
    output logic                              push_o,
    output logic                              pop_o,
    output logic [WIDTH-1:0]                  data_o,
    output logic [ADDR_WIDTH-1:0]             addr_o,
    output logic                              commit,
    output logic                              stage_flush,
    output logic [ADDR_WIDTH-1:0]             tos_addr,
    output logic [$clog2(MAX_INFLIGHT):0]     inflight
);

    localparam int IW = $clog2(MAX_INFLIGHT) + 1;
    localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   DEPTH_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [1:0] D_ZERO = 2'b00;
    localparam logic [1:0] D_INC  = 2'b01;
    localparam logic [1:0] D_DEC  = 2'b11;

    typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   spec_ptr_q, spec_ptr_d, com_ptr_q, com_ptr_d;
    logic [ADDR_WIDTH:0]     spec_depth_q, spec_depth_d, com_depth_q, com_depth_d;
    logic [IW-1:0]           inflight_q, inflight_d;
    logic [PW-1:0]           rd_q, rd_d, wr_q, wr_d;
    logic [1:0]              fifo_q [MAX_INFLIGHT];
    logic                    trigger_q, trigger_d, push_q, push_d, pop_q, pop_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    fifo_we;
    logic                    accept, op_valid, eff_ret;
    logic [1:0]              delta;

    function automatic logic [ADDR_WIDTH-1:0] ptr_add(input logic [ADDR_WIDTH-1:0] p,
                                                      input logic [1:0] dl);
        case (dl)
            D_INC:   ptr_add = p + PTR_ONE;
            D_DEC:   ptr_add = p - PTR_ONE;
            default: ptr_add = p;
        endcase
    endfunction

    function automatic logic [ADDR_WIDTH:0] depth_add(input logic [ADDR_WIDTH:0] d,
                                                      input logic [1:0] dl);
        case (dl)
            D_INC:   depth_add = (d == DEPTH_MAX) ? d : d + DEPTH_ONE;
            D_DEC:   depth_add = (d == '0) ? d : d - DEPTH_ONE;
            default: depth_add = d;
        endcase
    endfunction

    function automatic logic [PW-1:0] idx_inc(input logic [PW-1:0] i);
        idx_inc = (i == PW'(MAX_INFLIGHT - 1)) ? '0 : i + PW'(1);
    endfunction

    assign req_ready   = (inflight_q < IW'(MAX_INFLIGHT)) && !flush && (state_q == RUN);
    assign commit      = (state_q == RUN) && commit_i && (inflight_q != '0);
    assign stage_flush = (state_q == RECOVER);
    assign accept      = req_valid && req_ready;
    assign op_valid    = accept && (req_call || req_ret);
`ifdef RAS_UNDERFLOW_GUARD_EN
    // A ret on an empty stack is neutralised so the pointer cannot underflow.
    assign eff_ret     = req_ret && (spec_depth_q != '0);
`else
    assign eff_ret     = req_ret;
`endif
    assign delta = (req_call && !eff_ret) ? D_INC :
                   (!req_call && eff_ret) ? D_DEC : D_ZERO;

    always_comb begin
        state_d      = state_q;
        spec_ptr_d   = spec_ptr_q;
        com_ptr_d    = com_ptr_q;
        spec_depth_d = spec_depth_q;
        com_depth_d  = com_depth_q;
        inflight_d   = inflight_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        trigger_d    = 1'b0;
        push_d       = 1'b0;
        pop_d        = 1'b0;
        data_d       = data_q;
        addr_d       = addr_q;
        fifo_we      = 1'b0;

        if (commit) begin
            com_ptr_d   = ptr_add(com_ptr_q, fifo_q[rd_q]);
            com_depth_d = depth_add(com_depth_q, fifo_q[rd_q]);
            rd_d        = idx_inc(rd_q);
        end

        if (flush) begin
            // Restore uses the post-commit view so a same-cycle retire survives.
            state_d      = RECOVER;
            spec_ptr_d   = com_ptr_d;
            spec_depth_d = com_depth_d;
            inflight_d   = '0;
            rd_d         = '0;
            wr_d         = '0;
        end else if (state_q == RECOVER) begin
            state_d = RUN;
        end else begin
            if (op_valid) begin
                trigger_d    = 1'b1;
                push_d       = req_call;
                pop_d        = eff_ret;
                data_d       = req_data;
                addr_d       = (delta == D_INC) ? spec_ptr_q : spec_ptr_q - PTR_ONE;
                spec_ptr_d   = ptr_add(spec_ptr_q, delta);
                spec_depth_d = depth_add(spec_depth_q, delta);
                fifo_we      = 1'b1;
                wr_d         = idx_inc(wr_q);
            end
            inflight_d = inflight_q + IW'(op_valid) - IW'(commit);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            spec_ptr_q   <= '0;
            com_ptr_q    <= '0;
            spec_depth_q <= '0;
            com_depth_q  <= '0;
            inflight_q   <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            trigger_q    <= 1'b0;
            push_q       <= 1'b0;
            pop_q        <= 1'b0;
            data_q       <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            spec_ptr_q   <= spec_ptr_d;
            com_ptr_q    <= com_ptr_d;
            spec_depth_q <= spec_depth_d;
            com_depth_q  <= com_depth_d;
            inflight_q   <= inflight_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            trigger_q    <= trigger_d;
            push_q       <= push_d;
            pop_q        <= pop_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
        end
    end

    // Delta storage needs no reset: occupancy is tracked by inflight and the indices.
    always_ff @(posedge clk) begin
        if (fifo_we) begin
            fifo_q[wr_q] <= delta;
        end
    end

    assign trigger  = trigger_q;
    assign push_o   = push_q;
    assign pop_o    = pop_q;
    assign data_o   = data_q;
    assign addr_o   = addr_q;
    assign tos_addr = spec_ptr_q - PTR_ONE;
    assign inflight = inflight_q;

endmodule
`default_nettype wire
